apply_iteration_end_buffered: RTL and testbench
===============================================

Name: apply_iteration_end_buffered

Overview:
- Per-core buffered successor stage between the apply datapath and the next-iteration active-vertex logic.
- Each core gets a parametrised FIFO of active-vertex results, backpressure toward the next stage, and an almost-full indication toward apply.
- Per-core iteration_end is released only after that core's buffered vertices have fully drained.
- All cores are aggregated into a global iteration-done pulse and an iteration counter.

Parameters:
- V_ID_WIDTH, `V_ID_WIDTH: vertex id width.
- CORE_NUM, `CORE_NUM: number of cores/channels.
- ITERATION_WIDTH, `ITERATION_WIDTH: iteration counter width.
- FIFO_DEPTH, 16: per-core entries; power of two, >=4.
- ALMOST_FULL_MARGIN, 4: free-entry threshold for almost_full; must be <FIFO_DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  CORE_NUM  per-core reset; synchronous, active-high. rst[0] also resets the global logic.
- front_active_v_id  in  CORE_NUM*V_ID_WIDTH  vertex id, core i at [i*V_ID_WIDTH +: V_ID_WIDTH].
- front_active_v_updated  in  CORE_NUM  vertex value changed.
- front_active_v_valid  in  CORE_NUM  push strobe.
- front_iteration_end  in  CORE_NUM  upstream end-of-iteration flag.
- front_iteration_end_valid  in  CORE_NUM  qualifies front_iteration_end.
- next_stage_full  in  CORE_NUM  downstream cannot accept this cycle.
- buffer_almost_full  out  CORE_NUM  registered; count >= FIFO_DEPTH-ALMOST_FULL_MARGIN.
- buffer_overflow  out  CORE_NUM  sticky; push was attempted while the FIFO was full.
- active_v_id  out  CORE_NUM*V_ID_WIDTH  registered vertex id.
- active_v_updated  out  CORE_NUM  registered.
- active_v_valid  out  CORE_NUM  registered, one-cycle strobe per vertex.
- iteration_end  out  CORE_NUM  core drained and end seen.
- iteration_end_valid  out  CORE_NUM  registered copy of front_iteration_end_valid.
- all_iteration_end  out  1  one-cycle pulse when all cores reach DONE.
- iteration_count  out  ITERATION_WIDTH  completed iterations.

Behaviour:
- Reset: all outputs 0, FIFO empty, state RUN, overflow cleared, iteration_count 0. A mid-operation rst[i] flushes core i's FIFO and state only; the other cores continue.

Per-core FIFO:
- Push: when front_active_v_valid[i] and not full.
- Push while full: entry dropped, buffer_overflow[i] set until reset, contents unchanged.
- Pop: when FIFO non-empty and next_stage_full[i]==0. The head is registered onto active_v_* with active_v_valid=1 the next cycle; otherwise active_v_valid=0 and id/updated are 0.
- Latency: push into an empty FIFO appears on the output 2 cycles later when not stalled.
- Push and pop may occur in the same cycle; count is unchanged. Push on full with a simultaneous pop is accepted, not dropped.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Per-core FSM:
- RUN: on front_iteration_end_valid && front_iteration_end, go to DRAIN.
- DRAIN: go to DONE in the first cycle where the FIFO is empty, no push occurs, and no pop occurs.
- DONE: iteration_end[i]=1, held. Go to RUN when front_iteration_end_valid && !front_iteration_end, or on all_iteration_end.
- A vertex push while in DRAIN or DONE is accepted. In DONE it returns the core to DRAIN.
- iteration_end[i] is 0 outside DONE.

Global:
- all_iteration_end pulses for 1 cycle when every core is in DONE. Next cycle every core returns to RUN.
- iteration_count increments by 1 on each pulse and wraps at 2^ITERATION_WIDTH.
- rst[0] clears all_iteration_end and iteration_count.

Optional Feature:
- Macro APPLY_ITER_END_CONVERGE_EN.
- When defined, two extra outputs exist:
  - updated_count: 32-bit saturating count of popped vertices with updated=1, across all cores, in the current iteration. Multiple cores may pop in one cycle; add the popcount.
  - converged: 1-cycle pulse coincident with all_iteration_end when updated_count==0.
- updated_count clears on the cycle after all_iteration_end and on rst[0].
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- CORE_NUM=2, FIFO_DEPTH=16. Push ids 5,6,7 on core0 with next_stage_full=0 -> active_v_id 5,6,7 on consecutive cycles, first at push+2, valid=1; core1 stays 0.
- Hold next_stage_full[0]=1 and push 12 vertices -> buffer_almost_full[0]=1 at count 12, no pops. Release -> 12 pops in order, almost_full drops below 12.
- Push 17 while stalled -> buffer_overflow[0]=1 sticky. The 17th id never appears; the first 16 drain in order.
- Core0 end asserted with 3 entries buffered -> iteration_end[0]=0 until the last pop, then 1. Core1 already DONE -> all_iteration_end pulses once, iteration_count 0→1, both cores return to RUN.
- Assert rst[1] mid-drain -> core1 FIFO empty and outputs 0 next cycle; core0 stream unaffected; iteration_count unchanged.
- With APPLY_ITER_END_CONVERGE_EN: an iteration with 0 updated vertices -> converged pulses with all_iteration_end. An iteration with 3 updated -> updated_count=3 and no converged pulse.

Source files
------------

// File: rtl/apply_iteration_end_buffered.sv
// Per-core buffered successor stage: vertex FIFO, drain-gated iteration_end, global done pulse.
// Optional convergence tracking (updated_count/converged) when APPLY_ITER_END_CONVERGE_EN is defined.
module apply_iteration_end_buffered #(
  parameter int unsigned V_ID_WIDTH         = 16,
  parameter int unsigned CORE_NUM           = 2,
  parameter int unsigned ITERATION_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH         = 16,
  parameter int unsigned ALMOST_FULL_MARGIN = 4
) (
  input  logic                           clk,
  input  logic [CORE_NUM-1:0]            rst,
  input  logic [CORE_NUM*V_ID_WIDTH-1:0] front_active_v_id,
  input  logic [CORE_NUM-1:0]            front_active_v_updated,
  input  logic [CORE_NUM-1:0]            front_active_v_valid,
  input  logic [CORE_NUM-1:0]            front_iteration_end,
  input  logic [CORE_NUM-1:0]            front_iteration_end_valid,
  input  logic [CORE_NUM-1:0]            next_stage_full,
  output logic [CORE_NUM-1:0]            buffer_almost_full,
  output logic [CORE_NUM-1:0]            buffer_overflow,
  output logic [CORE_NUM*V_ID_WIDTH-1:0] active_v_id,
  output logic [CORE_NUM-1:0]            active_v_updated,
  output logic [CORE_NUM-1:0]            active_v_valid,
  output logic [CORE_NUM-1:0]            iteration_end,
  output logic [CORE_NUM-1:0]            iteration_end_valid,
`ifdef APPLY_ITER_END_CONVERGE_EN
  output logic [31:0]                    updated_count,
  output logic                           converged,
`endif
  output logic                           all_iteration_end,
  output logic [ITERATION_WIDTH-1:0]     iteration_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC   = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] AfThresh = CntW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  logic [CORE_NUM-1:0] done_vec;
  logic [CORE_NUM-1:0] pop_upd;
  logic                all_end;

  assign all_end = &done_vec;

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_core
    logic [V_ID_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wptr_q, rptr_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [V_ID_WIDTH:0]   head;
    logic                  empty, full, push, pop;
    state_e                state_q, state_d;
    logic [V_ID_WIDTH-1:0] id_q;
    logic                  upd_q, vld_q, af_q, ovf_q, iev_q;

    assign head  = mem_q[rptr_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DepthC);
    assign pop   = ~rst[i] & ~empty & ~next_stage_full[i];
    // A simultaneous pop frees a slot, so a push on full is still accepted.
    assign push  = ~rst[i] & front_active_v_valid[i] & (~full | pop);

    always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CntW'(1);
      else if (pop && !push) cnt_d = cnt_q - CntW'(1);
    end

    always_comb begin
      state_d = state_q;
      if (all_end) begin
        state_d = StRun;
      end else begin
        unique case (state_q)
          StRun:   if (front_iteration_end_valid[i] && front_iteration_end[i]) state_d = StDrain;
          StDrain: if (empty && !push && !pop) state_d = StDone;
          StDone: begin
            if (push) state_d = StDrain;
            else if (front_iteration_end_valid[i] && !front_iteration_end[i]) state_d = StRun;
          end
          default: state_d = StRun;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {front_active_v_updated[i],
                                  front_active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]};
    end

    always_ff @(posedge clk) begin
      if (rst[i]) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        cnt_q   <= '0;
        state_q <= StRun;
        id_q    <= '0;
        upd_q   <= 1'b0;
        vld_q   <= 1'b0;
        af_q    <= 1'b0;
        ovf_q   <= 1'b0;
        iev_q   <= 1'b0;
      end else begin
        if (push) wptr_q <= wptr_q + PtrW'(1);
        if (pop)  rptr_q <= rptr_q + PtrW'(1);
        cnt_q   <= cnt_d;
        state_q <= state_d;
        id_q    <= pop ? head[V_ID_WIDTH-1:0] : '0;
        upd_q   <= pop & head[V_ID_WIDTH];
        vld_q   <= pop;
        af_q    <= (cnt_d >= AfThresh);
        iev_q   <= front_iteration_end_valid[i];
        if (front_active_v_valid[i] && full && !pop) ovf_q <= 1'b1;
      end
    end

    assign done_vec[i]                               = (state_q == StDone);
    assign pop_upd[i]                                = pop & head[V_ID_WIDTH];
    assign active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]   = id_q;
    assign active_v_updated[i]                       = upd_q;
    assign active_v_valid[i]                         = vld_q;
    assign buffer_almost_full[i]                     = af_q;
    assign buffer_overflow[i]                        = ovf_q;
    assign iteration_end[i]                          = (state_q == StDone);
    assign iteration_end_valid[i]                    = iev_q;
  end

  logic [ITERATION_WIDTH-1:0] iter_q;

  always_ff @(posedge clk) begin
    if (rst[0])       iter_q <= '0;
    else if (all_end) iter_q <= iter_q + ITERATION_WIDTH'(1);
  end

  assign all_iteration_end = all_end;
  assign iteration_count   = iter_q;

`ifdef APPLY_ITER_END_CONVERGE_EN
  logic [31:0] upd_cnt_q;
  logic [32:0] upd_sum;

  always_comb begin
    upd_sum = {1'b0, upd_cnt_q};
    for (int unsigned k = 0; k < CORE_NUM; k++) begin
      upd_sum = upd_sum + 33'(pop_upd[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst[0] || all_end) upd_cnt_q <= '0;
    else                   upd_cnt_q <= upd_sum[32] ? 32'hFFFF_FFFF : upd_sum[31:0];
  end

  assign updated_count = upd_cnt_q;
  assign converged     = all_end & (upd_cnt_q == '0);
`else
  logic unused_pop_upd;
  assign unused_pop_upd = ^pop_upd;
`endif

endmodule

// File: tb/tb_apply_iteration_end_buffered.sv
// Randomized bench: per-cycle queue-based reference model of the buffered iteration-end stage.
module tb_apply_iteration_end_buffered;
  localparam int VW = 8, CN = 2, IW = 4, DEPTH = 16, MARGIN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [CN-1:0]    rst;
  logic [CN*VW-1:0] f_id;
  logic [CN-1:0]    f_upd, f_vld, f_end, f_endv, nsf;
  logic [CN-1:0]    af, ovf, a_upd, a_vld, ie, iev;
  logic [CN*VW-1:0] a_id;
  logic             all_end;
  logic [IW-1:0]    iter_cnt;
`ifdef APPLY_ITER_END_CONVERGE_EN
  logic [31:0]      upd_count;
  logic             conv;
`endif

  apply_iteration_end_buffered #(
    .V_ID_WIDTH(VW), .CORE_NUM(CN), .ITERATION_WIDTH(IW),
    .FIFO_DEPTH(DEPTH), .ALMOST_FULL_MARGIN(MARGIN)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .front_active_v_id        (f_id),
    .front_active_v_updated   (f_upd),
    .front_active_v_valid     (f_vld),
    .front_iteration_end      (f_end),
    .front_iteration_end_valid(f_endv),
    .next_stage_full          (nsf),
    .buffer_almost_full       (af),
    .buffer_overflow          (ovf),
    .active_v_id              (a_id),
    .active_v_updated         (a_upd),
    .active_v_valid           (a_vld),
    .iteration_end            (ie),
    .iteration_end_valid      (iev),
`ifdef APPLY_ITER_END_CONVERGE_EN
    .updated_count            (upd_count),
    .converged                (conv),
`endif
    .all_iteration_end        (all_end),
    .iteration_count          (iter_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain queues and a per-core phase number (0 run, 1 drain, 2 done).
  logic [VW:0]   mq [CN][$];
  int            mphase [CN];
  logic [VW-1:0] m_id [CN];
  logic          m_upd [CN], m_vld [CN], m_af [CN], m_ovf [CN], m_iev [CN];
  logic [IW-1:0] m_iter;
  longint        m_updcnt;
  int            seen_all_end = 0;
  int            seen_ovf     = 0;

  task automatic model_step();
    bit     all_pre = 1'b1;
    int     nupd = 0;
    for (int c = 0; c < CN; c++) if (mphase[c] != 2) all_pre = 1'b0;
    for (int c = 0; c < CN; c++) begin
      if (rst[c]) begin
        mq[c].delete();
        mphase[c] = 0;
        m_id[c] = '0; m_upd[c] = 0; m_vld[c] = 0; m_af[c] = 0; m_ovf[c] = 0; m_iev[c] = 0;
      end else begin
        int  size0 = mq[c].size();
        bit  pop   = (size0 > 0) && !nsf[c];
        bit  acc   = f_vld[c] && ((size0 < DEPTH) || pop);
        logic [VW:0] ent;
        if (f_vld[c] && size0 == DEPTH && !pop) m_ovf[c] = 1'b1;
        if (pop) begin
          ent = mq[c].pop_front();
          m_id[c] = ent[VW-1:0]; m_upd[c] = ent[VW]; m_vld[c] = 1'b1;
          if (ent[VW]) nupd++;
        end else begin
          m_id[c] = '0; m_upd[c] = 1'b0; m_vld[c] = 1'b0;
        end
        if (acc) mq[c].push_back({f_upd[c], f_id[c*VW +: VW]});
        if (all_pre) mphase[c] = 0;
        else if (mphase[c] == 0) begin
          if (f_endv[c] && f_end[c]) mphase[c] = 1;
        end else if (mphase[c] == 1) begin
          if (size0 == 0 && !acc) mphase[c] = 2;
        end else begin
          if (acc) mphase[c] = 1;
          else if (f_endv[c] && !f_end[c]) mphase[c] = 0;
        end
        m_af[c]  = (mq[c].size() >= DEPTH - MARGIN);
        m_iev[c] = f_endv[c];
      end
    end
    if (rst[0]) begin
      m_iter = '0; m_updcnt = 0;
    end else if (all_pre) begin
      m_iter = m_iter + 1'b1; m_updcnt = 0;
    end else begin
      m_updcnt = m_updcnt + nupd;
      if (m_updcnt > 64'hFFFF_FFFF) m_updcnt = 64'hFFFF_FFFF;
    end
  endtask

  task automatic check_all();
    bit exp_all = 1'b1;
    for (int c = 0; c < CN; c++) begin
      check_eq($sformatf("c%0d_id", c),    a_id[c*VW +: VW], m_id[c]);
      check_eq($sformatf("c%0d_upd", c),   a_upd[c],  m_upd[c]);
      check_eq($sformatf("c%0d_vld", c),   a_vld[c],  m_vld[c]);
      check_eq($sformatf("c%0d_af", c),    af[c],     m_af[c]);
      check_eq($sformatf("c%0d_ovf", c),   ovf[c],    m_ovf[c]);
      check_eq($sformatf("c%0d_ie", c),    ie[c],     (mphase[c] == 2));
      check_eq($sformatf("c%0d_iev", c),   iev[c],    m_iev[c]);
      if (mphase[c] != 2) exp_all = 1'b0;
      if (m_ovf[c]) seen_ovf++;
    end
    check_eq("all_end", all_end, exp_all);
    check_eq("iter_cnt", iter_cnt, m_iter);
    if (exp_all) seen_all_end++;
`ifdef APPLY_ITER_END_CONVERGE_EN
    check_eq("upd_count", upd_count, m_updcnt);
    check_eq("converged", conv, exp_all && (m_updcnt == 0));
`endif
  endtask

  task automatic drive_random(input int mode);
    int p_vld, p_nsf, p_endv, p_end;
    case (mode)
      0:       begin p_vld = 50; p_nsf = 20; p_endv = 10; p_end = 70; end
      1:       begin p_vld = 70; p_nsf = 90; p_endv = 5;  p_end = 50; end
      default: begin p_vld = 3;  p_nsf = 10; p_endv = 25; p_end = 90; end
    endcase
    for (int c = 0; c < CN; c++) begin
      rst[c]          = ($urandom_range(0, 299) == 0);
      f_id[c*VW +: VW] = VW'($urandom);
      f_upd[c]        = $urandom_range(0, 1);
      f_vld[c]        = ($urandom_range(0, 99) < p_vld);
      nsf[c]          = ($urandom_range(0, 99) < p_nsf);
      f_endv[c]       = ($urandom_range(0, 99) < p_endv);
      f_end[c]        = ($urandom_range(0, 99) < p_end);
    end
  endtask

  initial begin
    rst = '1; f_id = '0; f_upd = '0; f_vld = '0; f_end = '0; f_endv = '0; nsf = '0;
    m_iter = '0; m_updcnt = 0;
    for (int c = 0; c < CN; c++) begin
      mphase[c] = 0; m_id[c] = '0; m_upd[c] = 0; m_vld[c] = 0;
      m_af[c] = 0; m_ovf[c] = 0; m_iev[c] = 0;
    end
    #2;
    @(posedge clk); model_step(); #1; check_all();
    @(posedge clk); model_step(); #1; check_all();
    rst = '0;
    for (int blk = 0; blk < 16; blk++) begin
      for (int n = 0; n < 250; n++) begin
        drive_random(blk % 4);
        @(posedge clk); model_step(); #1; check_all();
      end
    end
    check_eq("saw_all_end", (seen_all_end > 0), 1'b1);
    check_eq("saw_overflow", (seen_ovf > 0), 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
